// File: rtl/tim_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tim_apb_pkg
// Purpose  : Shared types and constants for the timer APB requester.
//            Holds the bus widths, the requester FSM state encoding and the
//            packed command word that travels through the command FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package tim_apb_pkg;

    localparam int unsigned TIM_ADDR_W = 12;
    localparam int unsigned TIM_DATA_W = 32;
    localparam int unsigned TIM_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } tim_state_e;

    // 1 + 12 + 32 + 4 = 49 bits
    typedef struct packed {
        logic                  write;
        logic [TIM_ADDR_W-1:0] addr;
        logic [TIM_DATA_W-1:0] wdata;
        logic [TIM_STRB_W-1:0] strb;
    } tim_cmd_t;

endpackage : tim_apb_pkg
`default_nettype wire

// File: rtl/tim_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tim_cmd_fifo
// Purpose  : Synchronous command FIFO, DEPTH entries of type T_CMD.
//            Head entry is presented combinationally on o_head; a pop simply
//            advances the read pointer. Pushes while full and pops while
//            empty are ignored.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_push/i_data - write strobe and entry
//            i_pop/o_head  - read strobe and current head entry
//            o_full/o_empty- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module tim_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T_CMD = logic [48:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T_CMD i_data,
    input  logic i_pop,
    output T_CMD o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T_CMD            r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    // One extra bit so that "full" (count == DEPTH) is representable.
    logic [c_AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

    // Storage needs no reset; occupancy flags guard every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : tim_cmd_fifo
`default_nettype wire

// File: rtl/tim_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tim_apb_master
// Purpose  : APB requester driving the timer's APB slave. Local commands
//            arrive on a valid/ready port, queue in tim_cmd_fifo and are
//            issued as SETUP/ACCESS transfers honouring pready wait states.
//            Each completed transfer produces a one-cycle response pulse.
// Ports    : sys_clk, sys_rst          - clock, synchronous active-high reset
//            cmd_*                      - command input (valid/ready)
//            tim_psel..tim_pstrb        - APB request outputs
//            tim_prdata, tim_pready     - APB completion inputs
//            rsp_valid/write/rdata/err  - completion pulse and payload
//            busy                       - queue non-empty or transfer active
// Options  : TIM_APB_TIMEOUT_EN - when defined, an ACCESS phase that waits
//            TIMEOUT_CYCLES cycles without pready is aborted with rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module tim_apb_master
    import tim_apb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [TIM_ADDR_W-1:0] cmd_addr,
    input  logic [TIM_DATA_W-1:0] cmd_wdata,
    input  logic [TIM_STRB_W-1:0] cmd_strb,
    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_write,
    output logic [TIM_ADDR_W-1:0] tim_paddr,
    output logic [TIM_DATA_W-1:0] tim_pwdata,
    output logic [TIM_STRB_W-1:0] tim_pstrb,
    input  logic [TIM_DATA_W-1:0] tim_prdata,
    input  logic                  tim_pready,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [TIM_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    tim_state_e r_state;
    tim_state_e w_state_nxt;

    tim_cmd_t w_cmd_in;
    tim_cmd_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_done;
    logic     w_abort;

    logic                  r_write;
    logic [TIM_ADDR_W-1:0] r_paddr;
    logic [TIM_DATA_W-1:0] r_pwdata;
    logic [TIM_STRB_W-1:0] r_pstrb;

    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [TIM_DATA_W-1:0] r_rsp_rdata;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_in       = '0;
        w_cmd_in.write = cmd_write;
        w_cmd_in.addr  = cmd_addr;
        w_cmd_in.wdata = cmd_wdata;
        w_cmd_in.strb  = cmd_strb;
    end

    // No pass-through: a full queue refuses even when a pop is under way.
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    tim_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .T_CMD (tim_cmd_t)
    ) u_cmd_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_SETUP;
                    w_pop       = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // An abort retires the transfer exactly like a ready.
                if (tim_pready || w_abort) begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_state_nxt = ST_SETUP;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are loaded only on pop, which keeps them stable from
    // SETUP through the last ACCESS cycle. Reads carry no data/strobes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_write  <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_pop) begin
            r_write  <= w_head.write;
            r_paddr  <= w_head.addr;
            r_pwdata <= w_head.write ? w_head.wdata : '0;
            r_pstrb  <= w_head.write ? w_head.strb  : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_write <= w_done && r_write;
            r_rsp_rdata <= (w_done && !r_write && !w_abort) ? tim_prdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Optional ACCESS-phase watchdog
    // ------------------------------------------------------------------
`ifdef TIM_APB_TIMEOUT_EN
    localparam int unsigned c_TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TCNT_W-1:0] r_tcnt;
    logic                r_rsp_err;

    assign w_abort = (r_state == ST_ACCESS) && !tim_pready &&
                     (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tcnt    <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_abort;
            if ((w_state_nxt == ST_ACCESS) && (r_state != ST_ACCESS)) begin
                r_tcnt <= '0;
            end else if ((r_state == ST_ACCESS) && !tim_pready) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_abort = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tim_psel    = (r_state != ST_IDLE);
    assign tim_penable = (r_state == ST_ACCESS);
    assign tim_write   = r_write;
    assign tim_paddr   = r_paddr;
    assign tim_pwdata  = r_pwdata;
    assign tim_pstrb   = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign busy        = !w_empty || (r_state != ST_IDLE);

endmodule : tim_apb_master
`default_nettype wire

// File: tb/tb_tim_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_tim_apb_master
// Purpose  : Self-checking bench for tim_apb_master. A queue-based reference
//            model tracks queued commands, the bus phase and expected
//            responses; directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tim_apb_master;

    localparam int unsigned c_DEPTH = 4;
    localparam int unsigned c_TO    = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        tim_psel;
    logic        tim_penable;
    logic        tim_write;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata;
    logic        tim_pready;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    tim_apb_master #(
        .CMD_DEPTH      (c_DEPTH),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_write   (tim_write),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .rsp_valid   (rsp_valid),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queued commands, bus phase, current transfer.
    // ------------------------------------------------------------------
    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } cmd_s;

    cmd_s q[$];
    cmd_s cur;
    int   ph        = 0;   // 0 = no transfer, 1 = setup, 2 = access
    bit   exp_ready = 1'b0;
    int   waits     = 0;

    // One clock: inputs held from the caller are sampled at the rising
    // edge, outputs are compared at the following falling edge.
    task automatic tick();
        bit          acc;
        bit          fin;
        bit          rv;
        bit          rerr;
        bit          zero;
        logic        rw;
        logic [31:0] rd;
        cmd_s        c;
        @(posedge sys_clk);
        @(negedge sys_clk);
        rv = 0; rerr = 0; zero = 0; rw = 0; rd = '0;
        acc = cmd_valid && exp_ready && !sys_rst;
        c.wr = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata; c.strb = cmd_strb;
        if (sys_rst) begin
            q.delete();
            ph    = 0;
            waits = 0;
            zero  = 1;
        end else begin
            case (ph)
                0: begin
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        ph  = 1;
                    end
                end
                1: begin
                    ph    = 2;
                    waits = 0;
                end
                default: begin
                    fin = tim_pready;
`ifdef TIM_APB_TIMEOUT_EN
                    if (!tim_pready && waits == int'(c_TO) - 1) begin
                        fin  = 1;
                        rerr = 1;
                    end
`endif
                    if (!fin) waits++;
                    if (fin) begin
                        rv = 1;
                        rw = cur.wr;
                        rd = (cur.wr || rerr) ? 32'h0 : tim_prdata;
                        if (q.size() > 0) begin
                            cur = q.pop_front();
                            ph  = 1;
                        end else begin
                            ph = 0;
                        end
                    end
                end
            endcase
            if (acc) q.push_back(c);
        end

        chk("psel",    32'(tim_psel),    32'(ph != 0));
        chk("penable", 32'(tim_penable), 32'(ph == 2));
        if (ph != 0) begin
            chk("paddr",  32'(tim_paddr),  32'(cur.addr));
            chk("pwrite", 32'(tim_write),  32'(cur.wr));
            chk("pwdata", tim_pwdata,      cur.wr ? cur.wdata : 32'h0);
            chk("pstrb",  32'(tim_pstrb),  cur.wr ? 32'(cur.strb) : 32'h0);
        end
        if (zero) begin
            chk("rst_paddr",  32'(tim_paddr),  32'h0);
            chk("rst_pwrite", 32'(tim_write),  32'h0);
            chk("rst_pwdata", tim_pwdata,      32'h0);
            chk("rst_pstrb",  32'(tim_pstrb),  32'h0);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv || zero) begin
            chk("rsp_write", 32'(rsp_write), 32'(rw));
            chk("rsp_rdata", rsp_rdata,      rd);
        end
        chk("rsp_err", 32'(rsp_err), 32'(rerr));
        exp_ready = (q.size() < int'(c_DEPTH));
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'((q.size() > 0) || (ph != 0)));
    endtask

    task automatic clr_cmd();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 12'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    task automatic set_cmd(input logic wr, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    // Offer one command until the model says it was taken (bounded).
    task automatic push_cmd(input logic wr, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        bit taken;
        taken = 0;
        set_cmd(wr, a, d, s);
        for (int t = 0; t < 40 && !taken; t++) begin
            taken = exp_ready;
            tick();
        end
        chk("push_accepted", 32'(taken), 32'h1);
        clr_cmd();
    endtask

    initial begin
        int lat;
        int pen_cnt;
        int n_rsp;
        int last;

        sys_rst    = 1'b1;
        tim_pready = 1'b1;
        tim_prdata = '0;
        clr_cmd();
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();

        // Single write, pready held high: response 3 cycles after accept.
        set_cmd(1'b1, 12'h004, 32'h0000_0001, 4'hF);
        tick();
        clr_cmd();
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rsp_valid && lat == 0) lat = i;
        end
        chk("wr_latency", 32'(lat), 32'd3);

        // Read with three wait states: response 6 cycles after accept.
        set_cmd(1'b0, 12'h010, $urandom, 4'hF);
        tick();
        clr_cmd();
        lat = 0;
        pen_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tim_pready = !(i >= 3 && i <= 5);
            tim_prdata = (i == 6) ? 32'hDEAD_BEEF : $urandom;
            tick();
            if (tim_penable) pen_cnt++;
            if (rsp_valid && lat == 0) begin
                lat = i;
                chk("rd_data", rsp_rdata, 32'hDEAD_BEEF);
            end
        end
        tim_pready = 1'b1;
        chk("rd_latency", 32'(lat), 32'd6);
        chk("rd_penable_cycles", 32'(pen_cnt), 32'd4);

        // Five commands against a stalled bus fill the queue, then drain.
        tim_pready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_cmd(1'($urandom_range(0, 1)), 12'(16 * k), $urandom, 4'($urandom));
        end
        chk("full_ready_low", 32'(cmd_ready), 32'h0);
        tim_pready = 1'b1;
        n_rsp = 0;
        last  = -1;
        for (int i = 0; i < 20; i++) begin
            tim_prdata = $urandom;
            tick();
            if (rsp_valid) begin
                if (last >= 0) chk("b2b_gap", 32'(i - last), 32'd2);
                last = i;
                n_rsp++;
            end
        end
        chk("b2b_count", 32'(n_rsp), 32'd5);

        // Reset while a transfer is in ACCESS with two commands queued.
        tim_pready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_cmd(1'b1, 12'(k + 1), $urandom, 4'hF);
        end
        chk("pre_rst_penable", 32'(tim_penable), 32'h1);
        sys_rst = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        sys_rst    = 1'b0;
        tim_pready = 1'b1;
        repeat (6) tick();

`ifdef TIM_APB_TIMEOUT_EN
        // Stalled slave: abort after c_TO ACCESS cycles, next runs normally.
        tim_pready = 1'b0;
        push_cmd(1'b0, 12'h020, $urandom, 4'hF);
        push_cmd(1'b1, 12'h024, $urandom, 4'h3);
        pen_cnt = (tim_penable) ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 30 && lat == 0; i++) begin
            tick();
            if (rsp_valid) begin
                lat = 1;
                chk("to_err", 32'(rsp_err), 32'h1);
            end else if (tim_penable) begin
                pen_cnt++;
            end
        end
        chk("to_seen", 32'(lat), 32'h1);
        chk("to_access_cycles", 32'(pen_cnt), 32'(c_TO));
        tim_pready = 1'b1;
        repeat (6) tick();
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            sys_rst    = ($urandom_range(0, 299) == 0);
            cmd_valid  = ($urandom_range(0, 99) < 55);
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_addr   = 12'($urandom);
            cmd_wdata  = $urandom;
            cmd_strb   = 4'($urandom);
            tim_pready = ($urandom_range(0, 3) != 0);
            tim_prdata = $urandom;
            tick();
        end

        sys_rst = 1'b0;
        clr_cmd();
        tim_pready = 1'b1;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tim_apb_master
`default_nettype wire
